// File: rtl/sad_search_ctrl.sv
// SAD search sequencer: scans NUM_CAND reference offsets against one BLK_LEN-pixel
// block and keeps the lowest sum of absolute differences and its candidate index.
module sad_search_ctrl #(
    parameter int PIX_W    = 8,
    parameter int BLK_LEN  = 16,
    parameter int NUM_CAND = 8,
    parameter int ADDR_W   = 8,
    parameter int SAD_W    = 12,
    localparam int IDX_W   = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1
) (
    input  logic              clk,
    input  logic              Mrst_n,
    input  logic              go,
    input  logic              abort,
    output logic              rd_en,
    output logic [ADDR_W-1:0] cur_addr,
    output logic [ADDR_W-1:0] ref_addr,
    input  logic [PIX_W-1:0]  cur_pix,
    input  logic [PIX_W-1:0]  ref_pix,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  best_idx,
    output logic [SAD_W-1:0]  best_sad
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_READ, S_DRAIN, S_CMP, S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(BLK_LEN - 1);
    localparam logic [IDX_W-1:0]  LAST_CAND = IDX_W'(NUM_CAND - 1);

    state_t            state_q;
    logic [IDX_W-1:0]  cand_q;
    logic [ADDR_W-1:0] pix_q;
    logic [ADDR_W-1:0] ref_q;
    logic              vld_q;
    logic [SAD_W-1:0]  acc_q;
    logic [SAD_W-1:0]  acc_d;
    logic [IDX_W-1:0]  best_idx_q;
    logic [SAD_W-1:0]  best_sad_q;

    // Both pixels are zero-extended so the subtraction cannot wrap before the magnitude.
    function automatic logic [SAD_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                  input logic [PIX_W-1:0] b);
        logic signed [PIX_W:0] d;
        logic [PIX_W:0]        m;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        m = d[PIX_W] ? (PIX_W+1)'(-d) : (PIX_W+1)'(d);
        return SAD_W'(m);
    endfunction

    always_comb begin
        acc_d = acc_q + abs_diff(cur_pix, ref_pix);
    end

    always_ff @(posedge clk or negedge Mrst_n) begin
        if (!Mrst_n) begin
            state_q    <= S_IDLE;
            cand_q     <= '0;
            pix_q      <= '0;
            ref_q      <= '0;
            vld_q      <= 1'b0;
            acc_q      <= '0;
            best_idx_q <= '0;
            best_sad_q <= '0;
        end else begin
            vld_q <= (state_q == S_READ);
            if (vld_q) begin
                acc_q <= acc_d;
            end
            if (state_q != S_IDLE && abort) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (go) begin
                            cand_q  <= '0;
                            state_q <= S_CLR;
                        end
                    end
                    S_CLR: begin
                        acc_q   <= '0;
                        pix_q   <= '0;
                        ref_q   <= ADDR_W'(cand_q);
                        state_q <= S_READ;
                    end
                    S_READ: begin
                        if (pix_q == LAST_PIX) begin
                            state_q <= S_DRAIN;
                        end else begin
                            pix_q <= pix_q + 1'b1;
                            ref_q <= ref_q + 1'b1;
                        end
                    end
                    S_DRAIN: state_q <= S_CMP;
                    S_CMP: begin
                        // Strict compare: ties keep the earlier (lower) candidate.
                        if (cand_q == '0 || acc_q < best_sad_q) begin
                            best_sad_q <= acc_q;
                            best_idx_q <= cand_q;
                        end
                        if (cand_q == LAST_CAND) begin
                            state_q <= S_DONE;
                        end else begin
                            cand_q  <= cand_q + 1'b1;
                            state_q <= S_CLR;
                        end
                    end
                    S_DONE:  state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign rd_en    = (state_q == S_READ);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign cur_addr = pix_q;
    assign ref_addr = ref_q;
    assign best_idx = best_idx_q;
    assign best_sad = best_sad_q;

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Directed bench for sad_search_ctrl: small (4x3) and default (16x8) instances,
// pixel memories with one-cycle read latency, expected results queued per run.
module tb_sad_search_ctrl;

    localparam int BLK_A = 4;
    localparam int NC_A  = 3;
    localparam int BLK_B = 16;
    localparam int NC_B  = 8;

    typedef struct {
        logic [31:0] idx;
        logic [31:0] sad;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        go_a = 1'b0, abort_a = 1'b0;
    logic        rd_a, busy_a, done_a;
    logic [7:0]  ca_a, ra_a;
    logic [7:0]  cp_a = '0, rp_a = '0;
    logic [1:0]  idx_a;
    logic [11:0] sad_a;

    logic        go_b = 1'b0, abort_b = 1'b0;
    logic        rd_b, busy_b, done_b;
    logic [7:0]  ca_b, ra_b;
    logic [7:0]  cp_b = '0, rp_b = '0;
    logic [2:0]  idx_b;
    logic [11:0] sad_b;

    logic [7:0] cur_a [0:63];
    logic [7:0] ref_a [0:63];
    logic [7:0] cur_b [0:63];
    logic [7:0] ref_b [0:63];

    int   checks   = 0;
    int   failures = 0;
    exp_t sbq[$];

    sad_search_ctrl #(.PIX_W(8), .BLK_LEN(BLK_A), .NUM_CAND(NC_A), .ADDR_W(8), .SAD_W(12)) dut_a (
        .clk(clk), .Mrst_n(rst_n), .go(go_a), .abort(abort_a), .rd_en(rd_a),
        .cur_addr(ca_a), .ref_addr(ra_a), .cur_pix(cp_a), .ref_pix(rp_a),
        .busy(busy_a), .done(done_a), .best_idx(idx_a), .best_sad(sad_a)
    );

    sad_search_ctrl dut_b (
        .clk(clk), .Mrst_n(rst_n), .go(go_b), .abort(abort_b), .rd_en(rd_b),
        .cur_addr(ca_b), .ref_addr(ra_b), .cur_pix(cp_b), .ref_pix(rp_b),
        .busy(busy_b), .done(done_b), .best_idx(idx_b), .best_sad(sad_b)
    );

    always @(posedge clk) begin
        if (rd_a) begin
            cp_a <= cur_a[ca_a[5:0]];
            rp_a <= ref_a[ra_a[5:0]];
        end
        if (rd_b) begin
            cp_b <= cur_b[ca_b[5:0]];
            rp_b <= ref_b[ra_b[5:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference search over the bench's own memory images.
    function automatic exp_t model(input int blk, input int nc, input logic use_b);
        exp_t r;
        int   best, bi, s, c, rv;
        best = 0;
        bi   = 0;
        for (int k = 0; k < nc; k++) begin
            s = 0;
            for (int p = 0; p < blk; p++) begin
                c  = use_b ? int'(cur_b[p]) : int'(cur_a[p]);
                rv = use_b ? int'(ref_b[k+p]) : int'(ref_a[k+p]);
                s += (c > rv) ? (c - rv) : (rv - c);
            end
            if (k == 0 || s < best) begin
                best = s;
                bi   = k;
            end
        end
        r.idx = 32'(bi);
        r.sad = 32'(best);
        return r;
    endfunction

    task automatic run_a(input int go2, input int go3, input int abort_c, input int rst_c,
                         input int exp_done_at, input int exp_rd, input int exp_busy);
        int   rd_cnt, busy_cnt, dn_cnt, done_at;
        exp_t e;
        rd_cnt = 0; busy_cnt = 0; dn_cnt = 0; done_at = 0;
        if (exp_done_at != 0) sbq.push_back(model(BLK_A, NC_A, 1'b0));
        @(negedge clk);
        go_a = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            go_a    = (cyc == go2 || cyc == go3);
            abort_a = (cyc == abort_c);
            if (cyc == rst_c) begin
                rst_n = 1'b0;
                #1;
                chk("rst_mid_rd_en", 32'(rd_a), 32'd0);
                chk("rst_mid_busy", 32'(busy_a), 32'd0);
                chk("rst_mid_best_idx", 32'(idx_a), 32'd0);
                chk("rst_mid_best_sad", 32'(sad_a), 32'd0);
            end else if (rst_c != 0 && cyc == rst_c + 1) begin
                rst_n = 1'b1;
            end
            if (rd_a)   rd_cnt++;
            if (busy_a) busy_cnt++;
            if (done_a) begin
                dn_cnt++;
                done_at = cyc;
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk("a_best_idx", 32'(idx_a), e.idx);
                    chk("a_best_sad", 32'(sad_a), e.sad);
                end else begin
                    chk("a_unexpected_done", 32'(cyc), 32'd0);
                end
            end
            if (abort_c != 0 && cyc == abort_c + 1) chk("abort_busy", 32'(busy_a), 32'd0);
        end
        go_a    = 1'b0;
        abort_a = 1'b0;
        chk("a_done_count", 32'(dn_cnt), (exp_done_at != 0) ? 32'd1 : 32'd0);
        if (exp_done_at != 0) chk("a_done_cycle", 32'(done_at), 32'(exp_done_at));
        chk("a_rd_cycles", 32'(rd_cnt), 32'(exp_rd));
        chk("a_busy_cycles", 32'(busy_cnt), 32'(exp_busy));
    endtask

    task automatic run_b();
        int   rd_cnt, busy_cnt, dn_cnt, done_at;
        exp_t e;
        rd_cnt = 0; busy_cnt = 0; dn_cnt = 0; done_at = 0;
        sbq.push_back(model(BLK_B, NC_B, 1'b1));
        @(negedge clk);
        go_b = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 170; cyc++) begin
            @(negedge clk);
            go_b = 1'b0;
            if (rd_b)   rd_cnt++;
            if (busy_b) busy_cnt++;
            if (done_b) begin
                dn_cnt++;
                done_at = cyc;
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk("b_best_idx", 32'(idx_b), e.idx);
                    chk("b_best_sad", 32'(sad_b), e.sad);
                    chk("b_best_sad_nowrap", 32'(sad_b), 32'd4080);
                end else begin
                    chk("b_unexpected_done", 32'(cyc), 32'd0);
                end
            end
        end
        chk("b_done_count", 32'(dn_cnt), 32'd1);
        chk("b_done_cycle", 32'(done_at), 32'd153);
        chk("b_rd_cycles", 32'(rd_cnt), 32'd128);
        chk("b_busy_cycles", 32'(busy_cnt), 32'd153);
    endtask

    task automatic load_a(input int pat);
        for (int i = 0; i < 64; i++) begin
            cur_a[i] = 8'd0;
            ref_a[i] = 8'd0;
        end
        for (int i = 0; i < BLK_A; i++) cur_a[i] = (pat == 1) ? 8'(i + 1) : 8'd5;
        for (int i = 0; i < BLK_A + NC_A - 1; i++)
            ref_a[i] = (pat == 1) ? ((i < 2) ? 8'd0 : 8'(i - 1)) : ((i % 2 == 0) ? 8'd9 : 8'd1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            cur_b[i] = (i < BLK_B) ? 8'd255 : 8'd0;
            ref_b[i] = 8'd0;
        end
        load_a(1);

        repeat (2) @(negedge clk);
        chk("reset_rd_en", 32'(rd_a), 32'd0);
        chk("reset_cur_addr", 32'(ca_a), 32'd0);
        chk("reset_ref_addr", 32'(ra_a), 32'd0);
        chk("reset_busy", 32'(busy_a), 32'd0);
        chk("reset_done", 32'(done_a), 32'd0);
        chk("reset_best_idx", 32'(idx_a), 32'd0);
        chk("reset_best_sad", 32'(sad_a), 32'd0);
        rst_n = 1'b1;

        // Ascending pattern: SADs 7,4,0.
        run_a(0, 0, 0, 0, 22, 12, 22);
        chk("p1_best_idx_hold", 32'(idx_a), 32'd2);

        // Re-pulsed go mid-run and go during DONE are both ignored.
        run_a(5, 22, 0, 0, 22, 12, 22);

        // All-tie pattern keeps the lowest index.
        load_a(2);
        run_a(0, 0, 0, 0, 22, 12, 22);
        chk("tie_best_sad_hold", 32'(sad_a), 32'd16);

        // Abort during candidate 1 leaves candidate 0's committed result.
        load_a(1);
        run_a(0, 0, 10, 0, 0, 6, 10);
        chk("abort_best_idx", 32'(idx_a), 32'd0);
        chk("abort_best_sad", 32'(sad_a), 32'd7);

        // Async reset while reading, then a clean full search.
        run_a(0, 0, 0, 3, 0, 1, 2);
        run_a(0, 0, 0, 0, 22, 12, 22);

        // Default-sized instance at the accumulator's full-scale value.
        run_b();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sad_search_ctrl.md
# sad_search_ctrl

Sequencing controller for the SAD (sum of absolute differences) engine. On `go` it evaluates `NUM_CAND` candidate positions of a reference line against one `BLK_LEN`-pixel current block. For each candidate it issues paired pixel reads, accumulates |cur − ref|, and keeps the lowest SAD and its index. It replaces the single-shot SAD control FSM and sits between the pixel memories and the motion-search logic that consumes `best_idx`/`best_sad`.

## Interface
- `PIX_W`, 8, pixel width.
- `BLK_LEN`, 16, pixels per block (≥2).
- `NUM_CAND`, 8, candidate positions (≥1).
- `ADDR_W`, 8, address width; must hold `NUM_CAND+BLK_LEN−2`.
- `SAD_W`, 12, accumulator/result width; must be ≥ `PIX_W+clog2(BLK_LEN)`.
- `clk`  in  1  clock, rising edge.
- `Mrst_n`  in  1  reset, asynchronous, active-low.
- `go`  in  1  start request, sampled in IDLE only.
- `abort`  in  1  synchronous cancel, any non-IDLE state.
- `rd_en`  out  1  read strobe to both pixel memories.
- `cur_addr`  out  ADDR_W  current-block address.
- `ref_addr`  out  ADDR_W  reference-line address.
- `cur_pix`  in  PIX_W  current pixel, valid 1 cycle after `rd_en`.
- `ref_pix`  in  PIX_W  reference pixel, valid 1 cycle after `rd_en`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `best_idx`  out  clog2(NUM_CAND) (min 1)  index of the minimum-SAD candidate.
- `best_sad`  out  SAD_W  minimum SAD.

## Operation
- States: IDLE, CLR, READ, DRAIN, CMP, DONE.
- IDLE: `go` → CLR. Clear `cand` = 0. `best_*` keep their previous values until the first CMP.
- CLR: acc ← 0, `pix` ← 0, → READ.
- READ: `rd_en`=1, `cur_addr`=`pix`, `ref_addr`=`cand+pix`. `pix` increments each cycle. When `pix`==`BLK_LEN−1`, → DRAIN.
- Accumulate: a registered copy of `rd_en` (`vld_d`) gates acc ← acc + |cur_pix − ref_pix|. The difference is computed unsigned on PIX_W+1 bits, and the magnitude is taken. There is no saturation; the parameter rule guarantees no overflow.
- DRAIN: `rd_en`=0. The last pixel is accumulated. → CMP.
- CMP: if `cand`==0 or acc < `best_sad` (strict), then `best_sad` ← acc and `best_idx` ← `cand`. Ties keep the lower index.
  - If `cand`==`NUM_CAND−1`, → DONE.
  - Otherwise `cand`++ and → CLR.
- DONE: `done`=1 for this cycle only, → IDLE.
- `go` outside IDLE is ignored.
- `abort` (non-IDLE) → IDLE on the next edge. No `done`. `rd_en` drops. `best_*` keep their last committed values, which may be partial.
- `abort` has priority over all transitions, including DONE.
- Async reset: all state cleared immediately, mid-operation included.

## Timing
- Reset values: state IDLE, `rd_en`=0, `cur_addr`=`ref_addr`=0, `busy`=0, `done`=0, `best_idx`=0, `best_sad`=0, acc=0.
- Outputs `rd_en`, `busy` and `done` are decoded from state. Addresses are registered counters, aligned with `rd_en`.
- Memory read latency is fixed at 1 cycle.
- Let cycle 0 be the edge that samples `go`. Candidate k occupies cycles 1+k·(BLK_LEN+3) through (k+1)·(BLK_LEN+3).
- `done` is high in cycle `NUM_CAND·(BLK_LEN+3)+1`. `busy` is high from cycle 1 through that cycle.
- `best_*` are stable and valid when `done`=1 and remain until the next run's first CMP.
- A `go` in the DONE cycle is ignored. A new run may start from the following IDLE cycle.

## Test plan
- Bench parameters: BLK_LEN=4, NUM_CAND=3; per candidate 7 cycles, `done` at cycle 22.
- cur=[1,2,3,4], ref=[0,0,1,2,3,4] → candidate SADs 7, 4, 0 → `best_idx`=2, `best_sad`=0. `done` is a single pulse at cycle 22. `rd_en` is high 12 cycles total.
- cur=[5,5,5,5], ref=[9,1,9,1,9,1] → SADs 16, 16, 16 (tie) → `best_idx`=0, `best_sad`=16.
- Defaults (BLK_LEN=16), cur all 255, ref all 0 → `best_sad`=4080 with no wrap, `best_idx`=0. `done` at cycle 8·19+1=153.
- `go` re-pulsed at cycle 5 → ignored, `done` still at 22 only. `abort` at cycle 10 → IDLE at 11, no `done`, `busy`=0, `best_sad`=7 (cand 0 committed).
- `Mrst_n` low during READ → `rd_en`, `busy`, `best_*` all 0 immediately. After release, `go` runs a clean full search with correct results.
